// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard -- forwarding / hazard unit for the pipelined CPU.
//
// A shift-register scoreboard tracks in-flight register writers, one entry
// per stage after ID (entry 0 = EX, 1 = MEM, 2 = WB for DEPTH = 3). For each
// ID-stage source operand the youngest matching producer is chosen. Its
// result is forwarded if it is already available at that stage. Otherwise
// issue stalls.
//
// Ports:
//   clk          in   clock, all state on posedge
//   reset        in   async active-low reset, clears the scoreboard
//   issue_valid  in   ID holds a valid instruction
//   issue_wr     in   ID instruction writes a register
//   issue_rd     in   ID destination register
//   issue_rdy_at in   first stage index whose output carries the result
//   flush        in   squash the ID instruction
//   src_reg      in   NUM_SRC packed source indices (source i in slice i)
//   src_used     in   per-source valid
//   fwd_sel      out  per-source select: 0 = regfile, k = stage k-1 output
//   stall        out  hold PC and IF/ID, bubble into EX
//   stall_count  out  16-bit saturating stall-cycle counter
//
// Build option: define FWD_STALL_CNT_EN to build the stall counter.
// Without it stall_count is tied to zero.
// ---------------------------------------------------------------------------

// Per-source matcher: youngest valid entry with a matching rd decides.
module fwd_src_match #(
    parameter int DEPTH    = 3,
    parameter int REG_W    = 5,
    parameter int RDY_W    = 2,
    parameter int SEL_W    = 2,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_W-1:0]             src_reg,
    input  logic                         src_used,
    input  logic [DEPTH-1:0]             ent_v,
    input  logic [DEPTH-1:0][REG_W-1:0]  ent_rd,
    input  logic [DEPTH-1:0][RDY_W-1:0]  ent_rdy,
    output logic [SEL_W-1:0]             sel,
    output logic                         hazard
);
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        if (src_used && (src_reg != REG_W'(ZERO_REG))) begin
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_v[k] && (ent_rd[k] == src_reg)) begin
                    // rdy_at >= DEPTH can never satisfy this test.
                    // Such an entry stalls until it drops off the end.
                    if (k >= int'(ent_rdy[k])) begin
                        sel    = SEL_W'(k + 1);
                        hazard = 1'b0;
                    end else begin
                        sel    = '0;
                        hazard = 1'b1;
                    end
                end
            end
        end
    end
endmodule

module fwd_scoreboard #(
    parameter  int NUM_SRC  = 3,
    parameter  int DEPTH    = 3,
    parameter  int REG_W    = 5,
    parameter  int ZERO_REG = 31,
    localparam int SEL_W    = $clog2(DEPTH + 1),
    localparam int RDY_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic                       issue_wr,
    input  logic [REG_W-1:0]           issue_rd,
    input  logic [RDY_W-1:0]           issue_rdy_at,
    input  logic                       flush,
    input  logic [NUM_SRC*REG_W-1:0]   src_reg,
    input  logic [NUM_SRC-1:0]         src_used,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic [15:0]                stall_count
);
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][REG_W-1:0] ent_rd;
    logic [DEPTH-1:0][RDY_W-1:0] ent_rdy;
    logic [NUM_SRC-1:0]          hazard;
    logic                        load_e0;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .DEPTH(DEPTH), .REG_W(REG_W), .RDY_W(RDY_W),
            .SEL_W(SEL_W), .ZERO_REG(ZERO_REG)
        ) u_match (
            .src_reg  (src_reg[i*REG_W +: REG_W]),
            .src_used (src_used[i]),
            .ent_v    (vld_pipe),
            .ent_rd   (ent_rd),
            .ent_rdy  (ent_rdy),
            .sel      (fwd_sel[i*SEL_W +: SEL_W]),
            .hazard   (hazard[i])
        );
    end

    // flush wins over a hazard.
    assign stall   = issue_valid & ~flush & (|hazard);
    assign load_e0 = issue_valid & ~stall & ~flush & issue_wr &
                     (issue_rd != REG_W'(ZERO_REG));

    // Entries always advance, including while stalled. That is what
    // eventually resolves the hazard. Entry 0 takes the new writer or a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            ent_rd   <= '0;
            ent_rdy  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-2:0], load_e0};
            ent_rd   <= {ent_rd[DEPTH-2:0], issue_rd};
            ent_rdy  <= {ent_rdy[DEPTH-2:0], issue_rdy_at};
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_wr = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [1:0]  issue_rdy_at = '0;
    logic        flush = 1'b0;
    logic [14:0] src_reg = '0;
    logic [2:0]  src_used = '0;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_count;

    typedef struct {
        string       name;
        logic [5:0]  sel;
        logic        stl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    logic smp = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   tally = 0;     // stall cycles completed since reset

    fwd_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_rdy_at(issue_rdy_at), .flush(flush),
        .src_reg(src_reg), .src_used(src_used), .fwd_sel(fwd_sel),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] mk(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic wr, input logic [4:0] rd,
                             input logic [1:0] rdy);
        issue_valid = v; issue_wr = wr; issue_rd = rd; issue_rdy_at = rdy;
    endtask

    task automatic set_src(input logic [2:0] used, input logic [4:0] r0,
                           input logic [4:0] r1, input logic [4:0] r2);
        src_used = used; src_reg = {r2, r1, r0};
    endtask

    // Push expectation and strobe the monitor mid-cycle.
    task automatic chk(input string nm, input logic [5:0] sel, input logic stl);
        exp_t e;
        #1;
        e.name = nm; e.sel = sel; e.stl = stl;
`ifdef FWD_STALL_CNT_EN
        e.cnt = 16'(tally);
`else
        e.cnt = 16'd0;
`endif
        q.push_back(e);
        smp = 1'b1;
        #1 smp = 1'b0;
        if (stl) tally++;
    endtask

    // Monitor: pops and compares whenever the stimulus side strobes.
    initial begin
        exp_t e;
        forever begin
            @(posedge smp);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (fwd_sel !== e.sel || stall !== e.stl || stall_count !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: fwd_sel=%h want %h stall=%b want %b stall_count=%0d want %0d",
                             e.name, fwd_sel, e.sel, stall, e.stl, stall_count, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state: even with a would-be match, nothing forwards.
        cyc();
        set_src(3'b111, 5'd0, 5'd0, 5'd0);
        chk("reset_state", mk(0, 0, 0), 1'b0);
        cyc();
        reset = 1'b1;
        set_src(3'b000, 0, 0, 0);

        // ALU forwarding over distance
        cyc(); set_issue(1, 1, 5'd1, 2'd0); chk("alu_issue", mk(0, 0, 0), 0);
        cyc(); set_issue(0, 0, 0, 0); set_src(3'b001, 5'd1, 0, 0);
        chk("alu_d1", mk(1, 0, 0), 0);
        cyc(); chk("alu_d2", mk(2, 0, 0), 0);
        cyc(); chk("alu_d3", mk(3, 0, 0), 0);
        cyc(); chk("alu_gone", mk(0, 0, 0), 0);

        // Load-use: one stall, then forward from MEM output
        cyc(); set_src(3'b000, 0, 0, 0); set_issue(1, 1, 5'd2, 2'd1);
        chk("ld_issue", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 0, 0, 0); set_src(3'b010, 0, 5'd2, 0);
        chk("ld_use_stall", mk(0, 0, 0), 1);
        cyc(); chk("ld_use_fwd", mk(0, 2, 0), 0);
        cyc(); set_issue(0, 0, 0, 0); set_src(3'b000, 0, 0, 0);
        chk("ld_idle", mk(0, 0, 0), 0);

        // Youngest producer wins
        cyc(); set_issue(1, 1, 5'd3, 2'd0); chk("yw_issue_a", mk(0, 0, 0), 0);
        cyc(); chk("yw_issue_b", mk(0, 0, 0), 0);
        cyc(); set_issue(0, 0, 0, 0); set_src(3'b011, 5'd3, 5'd3, 0);
        chk("youngest_wins", mk(1, 1, 0), 0);

        // Zero register is never tracked
        cyc(); set_src(3'b000, 0, 0, 0); set_issue(1, 1, 5'd31, 2'd1);
        chk("zr_issue", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 0, 0, 0); set_src(3'b111, 5'd31, 5'd31, 5'd31);
        chk("zr_src", mk(0, 0, 0), 0);
        cyc(); chk("zr_src2", mk(0, 0, 0), 0);

        // Unused sources ignore matches
        cyc(); set_src(3'b000, 0, 0, 0); set_issue(1, 1, 5'd4, 2'd0);
        chk("unused_issue", mk(0, 0, 0), 0);
        cyc(); set_issue(0, 0, 0, 0); set_src(3'b000, 5'd4, 5'd4, 5'd4);
        chk("unused_src", mk(0, 0, 0), 0);
        cyc(); set_src(3'b100, 5'd4, 5'd4, 5'd4);
        chk("used_src2", mk(0, 0, 2), 0);

        // Flush beats a pending load-use hazard
        cyc(); set_src(3'b000, 0, 0, 0); set_issue(1, 1, 5'd2, 2'd1);
        chk("fl_issue", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 0, 0, 0); flush = 1'b1; set_src(3'b010, 0, 5'd2, 0);
        chk("flush_wins", mk(0, 0, 0), 0);
        cyc(); flush = 1'b0; chk("flush_after", mk(0, 2, 0), 0);

        // Never-forwardable writer stalls until it leaves the scoreboard
        cyc(); set_src(3'b000, 0, 0, 0); set_issue(1, 1, 5'd5, 2'd3);
        chk("nf_issue", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 0, 0, 0); set_src(3'b001, 5'd5, 0, 0);
        chk("nf_stall_e0", mk(0, 0, 0), 1);
        cyc(); chk("nf_stall_e1", mk(0, 0, 0), 1);
        cyc(); chk("nf_stall_e2", mk(0, 0, 0), 1);
        cyc(); chk("nf_released", mk(0, 0, 0), 0);

        // Reset in the middle of a stall
        cyc(); set_src(3'b000, 0, 0, 0); set_issue(1, 1, 5'd6, 2'd0);
        chk("rm_issue6", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 1, 5'd7, 2'd0); chk("rm_issue7", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 1, 5'd8, 2'd1); chk("rm_issue8", mk(0, 0, 0), 0);
        cyc(); set_issue(1, 0, 0, 0); set_src(3'b111, 5'd8, 5'd7, 5'd6);
        chk("rm_pre_stall", mk(0, 2, 3), 1);
        reset = 1'b0;
        tally = 0;
        chk("rm_reset_async", mk(0, 0, 0), 0);
        cyc(); reset = 1'b1; set_issue(0, 0, 0, 0); set_src(3'b000, 0, 0, 0);
        chk("rm_post", mk(0, 0, 0), 0);

        cyc();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined CPU. It keeps a shift-register scoreboard of in-flight register writers, one entry per pipeline stage after ID. For each of `NUM_SRC` ID-stage source operands it selects the youngest forwardable producer. It stalls issue when the youngest matching producer's result is not yet available, for example load-use.

## Interface
Parameters:
- `NUM_SRC`, 3 — source operands checked per cycle (Rn, Rm, store Rt).
- `DEPTH`, 3 — tracked stages after ID; stage 0 = EX, 1 = MEM, 2 = WB. Must be ≥ 2.
- `REG_W`, 5 — register index width.
- `ZERO_REG`, 31 — hard-wired zero register; never tracked, never forwarded.
- Derived widths: `SEL_W` = $clog2(DEPTH+1); `RDY_W` = max(1, $clog2(DEPTH)).

Ports:
- `clk`  in  1  — single clock; all state updates on posedge.
- `reset`  in  1  — asynchronous, active-low; clears all state while low.
- `issue_valid`  in  1  — ID holds a valid instruction this cycle.
- `issue_wr`  in  1  — the ID instruction writes a register.
- `issue_rd`  in  REG_W  — destination register of the ID instruction.
- `issue_rdy_at`  in  RDY_W  — first stage index whose output carries the result (0 = ALU, 1 = load).
- `flush`  in  1  — squash the ID instruction (taken branch).
- `src_reg`  in  NUM_SRC*REG_W  — source register indices; source i is in slice i.
- `src_used`  in  NUM_SRC  — per-source valid.
- `fwd_sel`  out  NUM_SRC*SEL_W  — per-source select: 0 = register file, k = output of stage k-1.
- `stall`  out  1  — hold PC and IF/ID; insert a bubble into EX.
- `stall_count`  out  16  — saturating stall-cycle count (see Configuration).

## Operation
- Scoreboard entry e[k], k = 0..DEPTH-1, holds {v, rd, rdy_at}.
- Match for source i: active only when `src_used[i]` is set and `src_reg[i]` ≠ ZERO_REG.
  - Find the smallest k with e[k].v and e[k].rd == src_reg[i]. The youngest producer wins.
- Select and hazard:
  - No match: fwd_sel[i] = 0.
  - Match with k ≥ e[k].rdy_at: fwd_sel[i] = k+1.
  - Match with k < e[k].rdy_at: hazard on source i; fwd_sel[i] = 0.
- `stall` = issue_valid & ~flush & (OR of all source hazards).
- Shift at every posedge: e[k] ← e[k-1] for k ≥ 1.
- e[0] load:
  - Loads {1, issue_rd, issue_rdy_at} when issue_valid & ~stall & ~flush & issue_wr & (issue_rd ≠ ZERO_REG).
  - Otherwise e[0].v ← 0 (bubble).
- The oldest entry falls off the end; it has already been written to the register file.
- `issue_rdy_at` ≥ DEPTH is treated as never forwardable. Any match on such an entry stalls until it leaves the scoreboard.

## Timing
- `fwd_sel` and `stall` are purely combinational from current entries and the current ID inputs; zero-cycle latency.
- A producer issued in cycle t occupies e[k] in cycle t+1+k.
- A consumer in cycle t+1+k sees fwd_sel = k+1 if k ≥ rdy_at.
- Load-use (rdy_at = 1) with the consumer immediately behind:
  - Exactly one stall cycle.
  - The next cycle gives fwd_sel = 2.
- Reset low (async): all e[k].v = 0 and stall_count = 0. Therefore fwd_sel = 0 and stall = 0 while reset is held.
- Reset asserted mid-stall cancels the stall immediately.
- flush and hazard in the same cycle: flush wins. stall = 0, a bubble enters e[0], older entries still shift.
- stall and the shift in the same cycle: entries e[0..] still advance, which is what resolves the hazard.
- stall_count increments by 1 on each posedge where stall = 1. It holds at 16'hFFFF.

## Configuration
- `FWD_STALL_CNT_EN` defined: the 16-bit saturating stall counter is built and drives `stall_count`.
- `FWD_STALL_CNT_EN` undefined: no counter flops; `stall_count` is tied to 16'd0.
- Forwarding and stall behaviour are identical in both builds.

## Test plan
- ALU distance forwarding: issue rd = 1, rdy_at = 0. Consumer src0 = 1 on the next three cycles → fwd_sel[0] = 1, then 2, then 3. On the fourth cycle → 0; stall stays 0 throughout.
- Load-use: issue rd = 2, rdy_at = 1; next cycle src1 = 2 → stall = 1, fwd_sel[1] = 0. Following cycle → stall = 0, fwd_sel[1] = 2; stall_count = 1 when enabled.
- Youngest wins: rd = 3 in e[1] and rd = 3 in e[0], src0 = src1 = 3 → fwd_sel[0] = fwd_sel[1] = 1.
- Zero register and unused sources:
  - Issue rd = 31: no later src = 31 ever forwards or stalls.
  - src_used = 0 with a matching reg → fwd_sel = 0.
- Flush priority: load-use hazard pending with flush = 1 → stall = 0. Next cycle e[0].v = 0, the load sits in e[1], and consumer src = 2 → fwd_sel = 2.
- Reset mid-operation: three valid entries and stall = 1; drop reset between edges → stall = 0, all fwd_sel = 0, stall_count = 0 immediately, without waiting for a clock edge.
